// File: rtl/target_config_table.sv
// Per-target address/length table: CSR-staged values commit on bus idle, CCC updates apply at once.
// Optional I3C_BCAST_MATCH_EN: lookups of 7'h7E always match slot 0.
module target_config_table #(
  parameter int NumTargets  = 2,
  parameter int LenResetVal = 256,
  localparam int IdxW = (NumTargets > 1) ? $clog2(NumTargets) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      bus_idle_i,
  input  logic                      cfg_wr_i,
  input  logic [IdxW-1:0]           cfg_idx_i,
  input  logic [6:0]                cfg_sta_addr_i,
  input  logic                      cfg_sta_valid_i,
  input  logic [6:0]                cfg_dyn_addr_i,
  input  logic                      cfg_dyn_valid_i,
  output logic [NumTargets-1:0]     cfg_pending_o,
  input  logic                      ccc_valid_i,
  input  logic [1:0]                ccc_op_i,
  input  logic [IdxW-1:0]           ccc_idx_i,
  input  logic [15:0]               ccc_data_i,
  output logic                      ccc_err_o,
  input  logic                      addr_valid_i,
  input  logic [6:0]                addr_i,
  output logic                      match_valid_o,
  output logic                      match_o,
  output logic [IdxW-1:0]           match_idx_o,
  output logic [7*NumTargets-1:0]   sta_addr_o,
  output logic [7*NumTargets-1:0]   dyn_addr_o,
  output logic [NumTargets-1:0]     sta_valid_o,
  output logic [NumTargets-1:0]     dyn_valid_o,
  output logic [16*NumTargets-1:0]  mwl_o,
  output logic [16*NumTargets-1:0]  mrl_o
);

  localparam logic [1:0] OpSetDyn = 2'b00;
  localparam logic [1:0] OpRstDaa = 2'b01;
  localparam logic [1:0] OpSetMwl = 2'b10;
  localparam logic [1:0] OpSetMrl = 2'b11;

  logic [6:0]  sta_addr_q [NumTargets];
  logic [6:0]  dyn_addr_q [NumTargets];
  logic        sta_valid_q [NumTargets];
  logic        dyn_valid_q [NumTargets];
  logic [15:0] mwl_q [NumTargets];
  logic [15:0] mrl_q [NumTargets];
  logic [6:0]  stg_sta_addr_q [NumTargets];
  logic [6:0]  stg_dyn_addr_q [NumTargets];
  logic        stg_sta_valid_q [NumTargets];
  logic        stg_dyn_valid_q [NumTargets];
  logic [NumTargets-1:0] pending_q;
  logic                  match_valid_q, match_q, ccc_err_q;
  logic [IdxW-1:0]       match_idx_q;

  logic            cfg_ok, ccc_ok, hit_any;
  logic [IdxW-1:0] hit_idx;

  assign cfg_ok = 32'(cfg_idx_i) < NumTargets;
  assign ccc_ok = 32'(ccc_idx_i) < NumTargets;

  // Lowest index wins: scan high to low so the last hit assigned is the smallest.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int k = NumTargets - 1; k >= 0; k--) begin
      if (dyn_valid_q[k] ? (dyn_addr_q[k] == addr_i)
                         : (sta_valid_q[k] && sta_addr_q[k] == addr_i)) begin
        hit_any = 1'b1;
        hit_idx = IdxW'(k);
      end
    end
`ifdef I3C_BCAST_MATCH_EN
    if (addr_i == 7'h7E) begin
      hit_any = 1'b1;
      hit_idx = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumTargets; k++) begin
        sta_addr_q[k]      <= '0;
        dyn_addr_q[k]      <= '0;
        sta_valid_q[k]     <= 1'b0;
        dyn_valid_q[k]     <= 1'b0;
        mwl_q[k]           <= 16'(LenResetVal);
        mrl_q[k]           <= 16'(LenResetVal);
        stg_sta_addr_q[k]  <= '0;
        stg_dyn_addr_q[k]  <= '0;
        stg_sta_valid_q[k] <= 1'b0;
        stg_dyn_valid_q[k] <= 1'b0;
      end
      pending_q     <= '0;
      match_valid_q <= 1'b0;
      match_q       <= 1'b0;
      match_idx_q   <= '0;
      ccc_err_q     <= 1'b0;
    end else begin
      match_valid_q <= addr_valid_i;
      match_q       <= addr_valid_i & hit_any;
      match_idx_q   <= addr_valid_i ? hit_idx : '0;
      ccc_err_q     <= ccc_valid_i && (ccc_op_i != OpRstDaa) && !ccc_ok;
      // Later assignments take priority: commit, then new staging write, then CCC.
      for (int k = 0; k < NumTargets; k++) begin
        if (bus_idle_i && pending_q[k]) begin
          sta_addr_q[k]  <= stg_sta_addr_q[k];
          sta_valid_q[k] <= stg_sta_valid_q[k];
          dyn_addr_q[k]  <= stg_dyn_addr_q[k];
          dyn_valid_q[k] <= stg_dyn_valid_q[k];
          pending_q[k]   <= 1'b0;
        end
        if (cfg_wr_i && cfg_ok && 32'(cfg_idx_i) == k) begin
          stg_sta_addr_q[k]  <= cfg_sta_addr_i;
          stg_sta_valid_q[k] <= cfg_sta_valid_i;
          stg_dyn_addr_q[k]  <= cfg_dyn_addr_i;
          stg_dyn_valid_q[k] <= cfg_dyn_valid_i;
          pending_q[k]       <= 1'b1;
        end
        if (ccc_valid_i) begin
          if (ccc_op_i == OpRstDaa) begin
            dyn_valid_q[k] <= 1'b0;
          end else if (ccc_ok && 32'(ccc_idx_i) == k) begin
            case (ccc_op_i)
              OpSetDyn: begin
                dyn_addr_q[k]  <= ccc_data_i[6:0];
                dyn_valid_q[k] <= 1'b1;
              end
              OpSetMwl: mwl_q[k] <= ccc_data_i;
              OpSetMrl: mrl_q[k] <= ccc_data_i;
              default:  ;
            endcase
          end
        end
      end
    end
  end

  for (genvar k = 0; k < NumTargets; k++) begin : g_out
    assign sta_addr_o[k*7 +: 7]  = sta_addr_q[k];
    assign dyn_addr_o[k*7 +: 7]  = dyn_addr_q[k];
    assign sta_valid_o[k]        = sta_valid_q[k];
    assign dyn_valid_o[k]        = dyn_valid_q[k];
    assign mwl_o[k*16 +: 16]     = mwl_q[k];
    assign mrl_o[k*16 +: 16]     = mrl_q[k];
  end

  assign cfg_pending_o = pending_q;
  assign ccc_err_o     = ccc_err_q;
  assign match_valid_o = match_valid_q;
  assign match_o       = match_q;
  assign match_idx_o   = match_idx_q;

endmodule

// File: tb/tb_target_config_table.sv
// Directed bench for target_config_table; three slots so that index 3 is an out-of-range encoding.
module tb_target_config_table;
  localparam int NT = 3;
  localparam int IW = 2;

  logic clk_i = 1'b0;
  logic rst_i, bus_idle_i, cfg_wr_i, cfg_sta_valid_i, cfg_dyn_valid_i;
  logic [IW-1:0] cfg_idx_i, ccc_idx_i;
  logic [6:0] cfg_sta_addr_i, cfg_dyn_addr_i, addr_i;
  logic [NT-1:0] cfg_pending_o, sta_valid_o, dyn_valid_o;
  logic ccc_valid_i, ccc_err_o, addr_valid_i, match_valid_o, match_o;
  logic [1:0] ccc_op_i;
  logic [15:0] ccc_data_i;
  logic [IW-1:0] match_idx_o;
  logic [7*NT-1:0] sta_addr_o, dyn_addr_o;
  logic [16*NT-1:0] mwl_o, mrl_o;

  int checks = 0;
  int errors = 0;

  target_config_table #(.NumTargets(NT), .LenResetVal(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus_idle_i(bus_idle_i),
    .cfg_wr_i(cfg_wr_i), .cfg_idx_i(cfg_idx_i), .cfg_sta_addr_i(cfg_sta_addr_i),
    .cfg_sta_valid_i(cfg_sta_valid_i), .cfg_dyn_addr_i(cfg_dyn_addr_i),
    .cfg_dyn_valid_i(cfg_dyn_valid_i), .cfg_pending_o(cfg_pending_o),
    .ccc_valid_i(ccc_valid_i), .ccc_op_i(ccc_op_i), .ccc_idx_i(ccc_idx_i),
    .ccc_data_i(ccc_data_i), .ccc_err_o(ccc_err_o),
    .addr_valid_i(addr_valid_i), .addr_i(addr_i),
    .match_valid_o(match_valid_o), .match_o(match_o), .match_idx_o(match_idx_o),
    .sta_addr_o(sta_addr_o), .dyn_addr_o(dyn_addr_o),
    .sta_valid_o(sta_valid_o), .dyn_valid_o(dyn_valid_o),
    .mwl_o(mwl_o), .mrl_o(mrl_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cfg(input logic [IW-1:0] idx, input logic [6:0] sa, input logic sv,
                         input logic [6:0] da, input logic dv);
    cfg_wr_i = 1'b1; cfg_idx_i = idx;
    cfg_sta_addr_i = sa; cfg_sta_valid_i = sv;
    cfg_dyn_addr_i = da; cfg_dyn_valid_i = dv;
  endtask

  task automatic set_ccc(input logic [1:0] op, input logic [IW-1:0] idx, input logic [15:0] d);
    ccc_valid_i = 1'b1; ccc_op_i = op; ccc_idx_i = idx; ccc_data_i = d;
  endtask

  task automatic do_ccc(input logic [1:0] op, input logic [IW-1:0] idx, input logic [15:0] d);
    set_ccc(op, idx, d);
    tick();
    ccc_valid_i = 1'b0;
  endtask

  task automatic lookup(input logic [6:0] a);
    addr_valid_i = 1'b1; addr_i = a;
    tick();
    addr_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; bus_idle_i = 1'b0; cfg_wr_i = 1'b0; cfg_idx_i = '0;
    cfg_sta_addr_i = '0; cfg_sta_valid_i = 1'b0; cfg_dyn_addr_i = '0; cfg_dyn_valid_i = 1'b0;
    ccc_valid_i = 1'b0; ccc_op_i = '0; ccc_idx_i = '0; ccc_data_i = '0;
    addr_valid_i = 1'b0; addr_i = '0;
    tick(); tick();
    rst_i = 1'b0;

    check("rst_pending", 64'(cfg_pending_o), 64'h0);
    check("rst_mwl", 64'(mwl_o), 64'h0100_0100_0100);
    check("rst_mrl", 64'(mrl_o), 64'h0100_0100_0100);
    check("rst_valids", 64'({sta_valid_o, dyn_valid_o}), 64'h0);
    check("rst_match", 64'({match_valid_o, match_o, match_idx_o, ccc_err_o}), 64'h0);

    // Staged write held off while bus busy, commits once idle
    set_cfg(2'd1, 7'h21, 1'b1, 7'h00, 1'b0);
    tick();
    cfg_wr_i = 1'b0;
    check("stage_pending", 64'(cfg_pending_o), 64'b010);
    check("stage_sta1_old", 64'(sta_addr_o[7 +: 7]), 64'h0);
    tick();
    check("stage_hold", 64'(cfg_pending_o), 64'b010);
    bus_idle_i = 1'b1;
    tick();
    bus_idle_i = 1'b0;
    check("commit_sta1", 64'(sta_addr_o[7 +: 7]), 64'h21);
    check("commit_staval", 64'(sta_valid_o), 64'b010);
    check("commit_pending", 64'(cfg_pending_o), 64'h0);

    // SETDYN, lookup, RSTDAA
    do_ccc(2'b00, 2'd0, 16'h0030);
    check("setdyn_addr0", 64'(dyn_addr_o[6:0]), 64'h30);
    check("setdyn_valid", 64'(dyn_valid_o), 64'b001);
    lookup(7'h30);
    check("lk30", 64'({match_valid_o, match_o, match_idx_o}), 64'b1_1_00);
    tick();
    check("lk_pulse_end", 64'(match_valid_o), 64'h0);
    lookup(7'h21);
    check("lk21_sta", 64'({match_valid_o, match_o, match_idx_o}), 64'b1_1_01);
    do_ccc(2'b01, 2'd3, 16'h0);
    check("rstdaa_valid", 64'(dyn_valid_o), 64'h0);
    check("rstdaa_keep", 64'(dyn_addr_o[6:0]), 64'h30);
    check("rstdaa_err", 64'(ccc_err_o), 64'h0);
    lookup(7'h30);
    check("lk30_miss", 64'({match_valid_o, match_o, match_idx_o}), 64'b1_0_00);

    // Duplicate effective addresses resolve to lowest slot
    do_ccc(2'b00, 2'd1, 16'h0045);
    do_ccc(2'b00, 2'd0, 16'h0045);
    lookup(7'h45);
    check("dup45", 64'({match_valid_o, match_o, match_idx_o}), 64'b1_1_00);
    do_ccc(2'b01, 2'd0, 16'h0);
    do_ccc(2'b00, 2'd2, 16'h0021);
    lookup(7'h21);
    check("dup21", 64'({match_valid_o, match_o, match_idx_o}), 64'b1_1_01);

    // Commit and SETDYN collide on slot 0: CCC keeps dyn, commit keeps sta
    set_cfg(2'd0, 7'h05, 1'b1, 7'h11, 1'b1);
    tick();
    cfg_wr_i = 1'b0;
    bus_idle_i = 1'b1;
    set_ccc(2'b00, 2'd0, 16'h0022);
    tick();
    ccc_valid_i = 1'b0; bus_idle_i = 1'b0;
    check("coll_dyn0", 64'(dyn_addr_o[6:0]), 64'h22);
    check("coll_dynval", 64'(dyn_valid_o[0]), 64'h1);
    check("coll_sta0", 64'(sta_addr_o[6:0]), 64'h05);
    check("coll_pending", 64'(cfg_pending_o), 64'h0);

    // Write and commit on the same slot in one cycle
    set_cfg(2'd2, 7'h12, 1'b1, 7'h00, 1'b0);
    tick();
    set_cfg(2'd2, 7'h13, 1'b1, 7'h00, 1'b0);
    bus_idle_i = 1'b1;
    tick();
    cfg_wr_i = 1'b0;
    check("wc_sta2_old", 64'(sta_addr_o[14 +: 7]), 64'h12);
    check("wc_pending", 64'(cfg_pending_o), 64'b100);
    tick();
    bus_idle_i = 1'b0;
    check("wc_sta2_new", 64'(sta_addr_o[14 +: 7]), 64'h13);
    check("wc_pending_clr", 64'(cfg_pending_o), 64'h0);

    // Out-of-range index handling
    do_ccc(2'b10, 2'd3, 16'h1234);
    check("oor_err", 64'(ccc_err_o), 64'h1);
    check("oor_mwl", 64'(mwl_o), 64'h0100_0100_0100);
    tick();
    check("oor_err_pulse", 64'(ccc_err_o), 64'h0);
    set_cfg(2'd3, 7'h33, 1'b1, 7'h00, 1'b0);
    tick();
    cfg_wr_i = 1'b0;
    check("oor_cfg", 64'(cfg_pending_o), 64'h0);
    do_ccc(2'b11, 2'd1, 16'h0040);
    check("setmrl1", 64'(mrl_o), 64'h0100_0040_0100);
    do_ccc(2'b10, 2'd2, 16'h00FF);
    check("setmwl2", 64'(mwl_o), 64'h00FF_0100_0100);

    // Lookup sees pre-update table in the CCC cycle
    set_ccc(2'b00, 2'd0, 16'h0050);
    addr_valid_i = 1'b1; addr_i = 7'h50;
    tick();
    ccc_valid_i = 1'b0; addr_valid_i = 1'b0;
    check("pre_update", 64'({match_valid_o, match_o}), 64'b10);
    lookup(7'h50);
    check("post_update", 64'({match_valid_o, match_o, match_idx_o}), 64'b1_1_00);

    // Reset in the middle of pending commit, CCC and lookup
    set_cfg(2'd1, 7'h44, 1'b1, 7'h00, 1'b0);
    tick();
    cfg_wr_i = 1'b0;
    check("pre_rst_pending", 64'(cfg_pending_o), 64'b010);
    rst_i = 1'b1;
    set_ccc(2'b00, 2'd1, 16'h0066);
    addr_valid_i = 1'b1; addr_i = 7'h50;
    tick();
    rst_i = 1'b0; ccc_valid_i = 1'b0; addr_valid_i = 1'b0;
    check("rst2_pending", 64'(cfg_pending_o), 64'h0);
    check("rst2_mwl", 64'(mwl_o), 64'h0100_0100_0100);
    check("rst2_mrl", 64'(mrl_o), 64'h0100_0100_0100);
    check("rst2_match", 64'({match_valid_o, match_o, ccc_err_o}), 64'h0);
    check("rst2_dyn", 64'(dyn_valid_o), 64'h0);
    bus_idle_i = 1'b1;
    tick();
    bus_idle_i = 1'b0;
    check("rst2_no_commit", 64'(sta_valid_o), 64'h0);

    lookup(7'h7E);
`ifdef I3C_BCAST_MATCH_EN
    check("bcast", 64'({match_valid_o, match_o, match_idx_o}), 64'b1_1_00);
`else
    check("bcast", 64'({match_valid_o, match_o, match_idx_o}), 64'b1_0_00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
